rom_port_arbiter: RTL
=====================

Name: rom_port_arbiter

Overview:
- Shares the single combinational read port of the program ROM between two requesters: the instruction-fetch port (IF) and the data-load port (LD).
- LD uses the port for constant/literal loads that target the ROM region.
- Sits between the fetch/LSU stages and the ROM.
- Grants one access per cycle, registers the read data and returns it one cycle later. A starvation counter keeps LD from locking out fetch.

Parameters:
- AW, `ADDRLEN, byte-address width of the ROM port.
- DW, `XLEN, data word width.
- STARVE_LIMIT, 4, number of consecutive denied IF cycles after which IF wins priority (range 1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request
- if_addr  in  AW  fetch byte address
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  fetch data valid (registered)
- if_rdata  out  DW  fetch data
- ld_req  in  1  load request
- ld_addr  in  AW  load byte address
- ld_gnt  out  1  load granted this cycle (combinational)
- ld_rvalid  out  1  load response valid (registered)
- ld_rdata  out  DW  load data
- ld_err  out  1  load response is a misalignment error, qualified by ld_rvalid
- rom_addr  out  AW  address to ROM
- rom_data  in  DW  ROM read data (combinational from rom_addr)

Behaviour:

Reset (asynchronous, active-low):
- All of if_rvalid, ld_rvalid, ld_err, if_rdata, ld_rdata, starve_cnt and prio_state go to 0 / LD_PRIO.
- Asserting rst_n low mid-transaction drops any pending response; no rvalid follows reset release.

Handshake:
- A requester holds req and addr stable until it sees gnt high at a rising edge.
- gnt is combinational from the req inputs and the current state, and is never asserted without req.
- On a granted cycle, rom_data is captured at the clock edge into that port's rdata register. rvalid is high for exactly the next cycle, so latency is 1.
- rdata holds its value until the next response on that port.
- A port may be re-granted back-to-back, giving one response per cycle.

Misaligned load (ld_addr[1:0] != 0):
- ld_gnt is asserted immediately without using the ROM.
- Next cycle: ld_rvalid=1, ld_err=1, ld_rdata=0.
- In the same cycle, if_req (if present) is granted the ROM.
- IF addresses are not checked for alignment: the low two bits are forced to 0 on rom_addr.

Arbitration, 2-state FSM with states LD_PRIO and IF_PRIO:
- LD_PRIO: an aligned ld_req wins; otherwise if_req wins.
- starve_cnt increments on each cycle where if_req=1 and if_gnt=0, saturating at STARVE_LIMIT.
- When starve_cnt reaches STARVE_LIMIT, the next state is IF_PRIO.
- IF_PRIO: if_req wins. After that IF grant the state returns to LD_PRIO and starve_cnt returns to 0.
- starve_cnt clears whenever if_gnt=1 or if_req=0.
- IF_PRIO with if_req=0 returns to LD_PRIO with no grant to IF.

rom_addr:
- Driven with the winner's address, low two bits zeroed.
- Holds its previous value when idle; no X output.

Concurrency and idle:
- Both ports may have rvalid high in the same cycle only in the misaligned-LD case.
- No request means no rvalid next cycle and no state change apart from the counter clear.

Decomposition:
- Shared package/defines: `ADDRLEN, `XLEN (already global), plus new defines ARB_LD_PRIO/ARB_IF_PRIO state encodings and a default ARB_STARVE_LIMIT.
- One natural sub-module: rom_resp_reg (per-port response register holding rvalid/rdata/err, instantiated twice).
- The FSM and counter stay in the top module.

Test Plan:
- Sequential fetches: if_req at addr 0x0, then 0x4 back-to-back -> if_gnt both cycles; if_rvalid on the following cycles with if_rdata 0x000002B3 then 0x00B00313.
- Contention: ld_req at 0x8 and if_req at 0x0 in the same cycle -> ld_gnt=1, if_gnt=0. The next cycle gives ld_rdata=0x10000397, and IF is granted in the following cycle.
- Starvation: ld_req held high for 10 cycles with if_req high (STARVE_LIMIT=4) -> if_gnt in cycle 5 and cycle 10, with ld_gnt in all other cycles.
- Misaligned load: ld_addr=0x6 together with if_req at 0xC -> both gnt the same cycle. Next cycle: ld_rvalid=1, ld_err=1, ld_rdata=0, and if_rdata=0xFF838393.
- Reset: rst_n low while a grant is in flight -> all rvalid outputs 0 immediately, no response after release, and the FSM is in LD_PRIO.
- Unaligned IF: if_addr=0x5 -> rom_addr=0x4, if_rdata=0x00B00313.

Source files
------------

// File: rtl/rom_port_arbiter_pkg.sv
// Shared widths, arbitration state encoding and default starvation limit
// for the program-ROM read-port arbiter.
package rom_port_arbiter_pkg;

  localparam int unsigned ADDRLEN          = 32;
  localparam int unsigned XLEN             = 32;
  localparam int unsigned ARB_STARVE_LIMIT = 4;
  localparam int unsigned CNT_W            = 4;

  typedef enum logic {
    ARB_LD_PRIO = 1'b0,
    ARB_IF_PRIO = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rom_resp_reg.sv
// Per-port response register: one-cycle rvalid pulse plus a payload that
// holds until the next response on that port.
module rom_resp_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         capture_i,
  input  logic [W-1:0] data_i,
  output logic         rvalid_o,
  output logic [W-1:0] data_o
);

  logic         rvalid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      data_q   <= '0;
    end else begin
      rvalid_q <= capture_i;
      if (capture_i) begin
        data_q <= data_i;
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign data_o   = data_q;

endmodule

// File: rtl/rom_port_arbiter.sv
// Arbitrates the single combinational program-ROM read port between
// instruction fetch and constant loads, with an anti-starvation counter for fetch.
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int unsigned AW           = ADDRLEN,
  parameter int unsigned DW           = XLEN,
  parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_err,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data
);

  localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(STARVE_LIMIT);
  localparam logic [AW-1:0]    WORD_MASK = ~AW'(3);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             ld_mis;
  logic             ld_err_q;

  // Misaligned loads are answered with an error and never occupy the ROM.
  assign ld_mis = ld_req && (ld_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_LD_PRIO;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    if_gnt  = 1'b0;
    ld_gnt  = 1'b0;

    if (ld_mis) begin
      ld_gnt = 1'b1;
      if_gnt = if_req;
    end else if (state_q == ARB_IF_PRIO) begin
      if_gnt = if_req;
      ld_gnt = ld_req && !if_req;
    end else if (ld_req) begin
      ld_gnt = 1'b1;
    end else begin
      if_gnt = if_req;
    end

    if (ld_gnt && !ld_mis) begin
      addr_d = ld_addr & WORD_MASK;
    end else if (if_gnt) begin
      addr_d = if_addr & WORD_MASK;
    end

    if (!if_req || if_gnt) begin
      cnt_d = '0;
    end else if (cnt_q < LIMIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // IF priority lasts a single cycle; it is entered once the counter saturates.
    if (state_q == ARB_IF_PRIO) begin
      state_d = ARB_LD_PRIO;
    end else if (cnt_d == LIMIT) begin
      state_d = ARB_IF_PRIO;
    end
  end

  assign rom_addr = addr_d;

  rom_resp_reg #(.W(DW)) u_if_resp (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture_i (if_gnt),
    .data_i    (rom_data),
    .rvalid_o  (if_rvalid),
    .data_o    (if_rdata)
  );

  rom_resp_reg #(.W(DW + 1)) u_ld_resp (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture_i (ld_gnt),
    .data_i    ({ld_mis, (ld_mis ? {DW{1'b0}} : rom_data)}),
    .rvalid_o  (ld_rvalid),
    .data_o    ({ld_err_q, ld_rdata})
  );

  assign ld_err = ld_rvalid && ld_err_q;

endmodule
